// File: rtl/sum_decimator.sv
// Decimating averager: sums 2^LOG2_N qualified samples and emits their mean through a one-deep valid/ready buffer.
// Optional SUM_DECIMATOR_ROUND_EN selects round-half-up instead of floor.
module sum_decimator #(
    parameter int DIM    = 14,
    parameter int LOG2_N = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [DIM-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  clear,
    output logic signed [DIM-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
);

    localparam int AW = DIM + LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

`ifdef SUM_DECIMATOR_ROUND_EN
    localparam logic signed [AW-1:0] RND = AW'(2 ** (LOG2_N - 1));
`else
    localparam logic signed [AW-1:0] RND = '0;
`endif

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // A window sum of N in-range samples plus the bias always fits AW bits,
    // so the shifted result needs only truncation, never saturation.
    function automatic logic signed [DIM-1:0] avg_of(input logic signed [AW-1:0] total);
        logic signed [AW-1:0] biased;
        biased = total + RND;
        return DIM'(biased >>> LOG2_N);
    endfunction

    logic signed [AW-1:0]  r_acc;
    logic [LOG2_N-1:0]     r_cnt;
    buf_state_t            r_state;
    logic signed [DIM-1:0] r_out_data;
    logic                  r_overrun;

    logic signed [AW-1:0]  w_sample_ext;
    logic signed [AW-1:0]  w_total;
    logic signed [DIM-1:0] w_result;
    logic                  w_accept;
    logic                  w_done;

    assign w_sample_ext = {{LOG2_N{in_data[DIM-1]}}, in_data};
    assign w_total      = r_acc + w_sample_ext;
    assign w_result     = avg_of(w_total);
    assign w_accept     = in_valid & ~clear;
    assign w_done       = w_accept & (r_cnt == CNT_LAST);

    assign out_data  = r_out_data;
    assign out_valid = (r_state == BUF_FULL);
    assign overrun   = r_overrun;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_state    <= BUF_EMPTY;
            r_out_data <= '0;
            r_overrun  <= 1'b0;
        end else begin
            // Window accumulation; clear beats a same-cycle sample.
            if (clear || w_done) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (in_valid) begin
                r_acc <= w_total;
                r_cnt <= r_cnt + LOG2_N'(1);
            end

            if (clear) begin
                r_overrun <= 1'b0;
            end else if (w_done && (r_state == BUF_FULL) && !out_ready) begin
                r_overrun <= 1'b1;
            end

            // Output buffer: a completion refills it, otherwise a handshake drains it.
            case (r_state)
                BUF_EMPTY: begin
                    if (w_done) begin
                        r_out_data <= w_result;
                        r_state    <= BUF_FULL;
                    end
                end
                BUF_FULL: begin
                    if (w_done) begin
                        if (out_ready) begin
                            r_out_data <= w_result;
                        end
                    end else if (out_ready) begin
                        r_state <= BUF_EMPTY;
                    end
                end
                default: r_state <= BUF_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_decimator.sv
// Self-checking bench for sum_decimator: directed scenarios plus randomized traffic against a window-list model.
module tb_sum_decimator;

    localparam int DIM    = 14;
    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;

`ifdef SUM_DECIMATOR_ROUND_EN
    localparam int RND       = N / 2;
    localparam int BASIC_EXP = 3;
    localparam int NEG_EXP   = -2;
`else
    localparam int RND       = 0;
    localparam int BASIC_EXP = 2;
    localparam int NEG_EXP   = -3;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic signed [DIM-1:0] in_data;
    logic                  in_valid;
    logic                  clear;
    logic signed [DIM-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  overrun;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending window samples and the visible output state.
    int win[$];
    bit m_valid;
    int m_data;
    bit m_ovr;

    sum_decimator #(.DIM(DIM), .LOG2_N(LOG2_N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .clear    (clear),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int floor_div_n(input int v);
        int q;
        q = v / N;
        if ((v % N != 0) && (v < 0)) q = q - 1;
        return q;
    endfunction

    task automatic step(input bit v, input int d, input bit c, input bit r);
        bit done;
        int sum;
        int res;
        @(negedge clk);
        in_valid  = v;
        in_data   = DIM'(d);
        clear     = c;
        out_ready = r;
        done = 1'b0;
        res  = 0;
        if (c) begin
            win.delete();
            m_ovr = 1'b0;
        end else if (v) begin
            win.push_back(int'(in_data));
            if (win.size() == N) begin
                sum = 0;
                foreach (win[i]) sum += win[i];
                res  = floor_div_n(sum + RND);
                win.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_valid) begin
                m_valid = 1'b1;
                m_data  = res;
            end else if (r) begin
                m_data = res;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_val("model_valid", int'(out_valid), int'(m_valid));
        chk_val("model_data", int'(out_data), m_data);
        chk_val("model_overrun", int'(overrun), int'(m_ovr));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = DIM'(100);
        clear     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        win.delete();
        m_valid = 1'b0;
        m_data  = 0;
        m_ovr   = 1'b0;
        chk_val("reset_valid", int'(out_valid), 0);
        chk_val("reset_data", int'(out_data), 0);
        chk_val("reset_overrun", int'(overrun), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic feed4(input int a, input int b, input int c, input int d);
        step(1'b1, a, 1'b0, 1'b1);
        step(1'b1, b, 1'b0, 1'b1);
        step(1'b1, c, 1'b0, 1'b1);
        step(1'b1, d, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        do_reset();

        // Basic window and single-cycle valid pulse.
        feed4(1, 2, 3, 4);
        chk_val("basic_valid", int'(out_valid), 1);
        chk_val("basic_data", int'(out_data), BASIC_EXP);
        step(1'b0, 0, 1'b0, 1'b1);
        chk_val("basic_pulse", int'(out_valid), 0);

        feed4(-1, -2, -3, -4);
        chk_val("neg_data", int'(out_data), NEG_EXP);
        step(1'b0, 0, 1'b0, 1'b1);

        feed4(8191, 8191, 8191, 8191);
        chk_val("max_data", int'(out_data), 8191);
        feed4(-8192, -8192, -8192, -8192);
        chk_val("min_data", int'(out_data), -8192);
        step(1'b0, 0, 1'b0, 1'b1);

        // Gaps inside a window.
        step(1'b1, 1, 1'b0, 1'b1);
        step(1'b0, 99, 1'b0, 1'b1);
        step(1'b1, 2, 1'b0, 1'b1);
        step(1'b0, 99, 1'b0, 1'b1);
        step(1'b1, 3, 1'b0, 1'b1);
        step(1'b1, 4, 1'b0, 1'b1);
        chk_val("gap_data", int'(out_data), BASIC_EXP);
        step(1'b0, 0, 1'b0, 1'b1);

        // Backpressure: second and later windows are discarded.
        for (int i = 0; i < 8; i++) step(1'b1, 5, 1'b0, 1'b0);
        chk_val("bp_data", int'(out_data), 5);
        chk_val("bp_valid", int'(out_valid), 1);
        chk_val("bp_overrun", int'(overrun), 1);
        for (int i = 0; i < 8; i++) step(1'b1, 9, 1'b0, 1'b0);
        chk_val("bp_hold_data", int'(out_data), 5);
        step(1'b0, 0, 1'b0, 1'b1);
        chk_val("bp_drain_valid", int'(out_valid), 0);
        chk_val("bp_drain_data", int'(out_data), 5);

        // Clear drops the partial window, the same-cycle sample and the overrun flag.
        step(1'b1, 7, 1'b0, 1'b1);
        step(1'b1, 7, 1'b0, 1'b1);
        step(1'b1, 7, 1'b1, 1'b1);
        chk_val("clr_overrun", int'(overrun), 0);
        feed4(1, 1, 1, 1);
        chk_val("clr_data", int'(out_data), 1);
        chk_val("clr_overrun2", int'(overrun), 0);
        step(1'b0, 0, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int d;
            if ($urandom_range(0, 9) == 0)
                d = ($urandom_range(0, 1) == 1) ? 8191 : -8192;
            else
                d = int'($urandom_range(0, 16383)) - 8192;
            step($urandom_range(0, 9) < 7, d, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) < 6);
        end
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);

        // Reset while FULL with overrun and a partial window pending.
        for (int i = 0; i < 8; i++) step(1'b1, 3, 1'b0, 1'b0);
        step(1'b1, 50, 1'b0, 1'b0);
        step(1'b1, 50, 1'b0, 1'b0);
        chk_val("prerst_overrun", int'(overrun), 1);
        do_reset();
        feed4(1, 2, 3, 4);
        chk_val("postrst_data", int'(out_data), BASIC_EXP);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
